// File: rtl/read_fifo_multi_req_ctrl_pkg.sv
// Shared types and constants for the read-FIFO request controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the controller state encoding, the FRAME_SYNC mode constants and a
// helper that sizes channel-index fields (never narrower than one bit).
package read_fifo_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQ       = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_FSH       = 2'd3
    } state_e;

    // FRAME_SYNC mode values, fixed at 24 bits so "ON" and "OFF" compare cleanly.
    localparam logic [23:0] FS_OFF = "OFF";
    localparam logic [23:0] FS_ON  = {8'h00, "ON"};

    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/read_fifo_multi_req_ctrl_if.sv
// Request handshake between the FIFO request controller and the read master.
// Latency: n/a (wiring only).
// Backpressure: request level is held by the master side until resp is seen.
//
// Signals:
//   burst_req / tail_req : request levels (master -> slave), never both high
//   req_ch / req_len     : channel and length of the current request
//   resp                 : request accepted (slave -> master)
//   done                 : request data fully written into the FIFO (slave -> master)
interface read_fifo_multi_req_ctrl_if
    import read_fifo_ctrl_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int LSIZE = 9
);
    logic                      burst_req;
    logic                      tail_req;
    logic [ch_idx_w(NCH)-1:0]  req_ch;
    logic [LSIZE-1:0]          req_len;
    logic                      resp;
    logic                      done;

    modport master (
        output burst_req, tail_req, req_ch, req_len,
        input  resp, done
    );

    modport slave (
        input  burst_req, tail_req, req_ch, req_len,
        output resp, done
    );
endinterface

// File: rtl/read_fifo_multi_req_ctrl_rr_arbiter.sv
// Round-robin arbiter: picks the first requesting channel at or after the pointer.
// Latency: grant is combinational from req; pointer updates one cycle after advance.
// Backpressure: pointer only moves when advance is asserted with a valid grant.
//
// Ports:
//   req[NCH]  : request vector
//   advance   : consume the current grant; pointer moves to the channel after it
//   gnt_idx   : granted channel index, gnt_vld : any request present
module rr_arbiter
    import read_fifo_ctrl_pkg::*;
#(
    parameter int NCH = 2
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  logic [NCH-1:0]           req,
    input  logic                     advance,
    output logic [ch_idx_w(NCH)-1:0] gnt_idx,
    output logic                     gnt_vld
);
    localparam int IW = ch_idx_w(NCH);

    logic [IW-1:0] ptr_q, ptr_d;
    int            idx;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = 0; k < NCH; k++) begin
            idx = (int'(ptr_q) + k) % NCH;
            if (!gnt_vld && req[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = IW'(idx);
            end
        end
    end

    // Pointer holds the first channel to search next time: one past the last grant.
    always_comb begin
        ptr_d = ptr_q;
        if (advance && gnt_vld) begin
            ptr_d = (gnt_idx == IW'(NCH - 1)) ? '0 : gnt_idx + IW'(1);
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/read_fifo_multi_req_ctrl.sv
// Multi-channel read-FIFO refill controller: issues one burst/tail read request at a time.
// Latency: request level rises 2 cycles after a channel's fill level drops below the trigger.
// Backpressure: request level is held until resp; next grant waits for done plus one flush cycle.
//
// Ports:
//   clock, rst_n        : clock, async active-low reset
//   enable[NCH]         : per-channel enable
//   count[NCH*CNT_W]    : per-channel FIFO fill level
//   tail_status[NCH]    : next read on that channel is the frame tail
//   tail_len[NCH*LSIZE] : per-channel tail length
//   frame_sync[NCH]     : frame-start pulse, arms a channel when FRAME_SYNC is "ON"
//   req_if (master)     : burst_req/tail_req/req_ch/req_len out, resp/done in
//   busy                : controller is not idle
module read_fifo_multi_req_ctrl
    import read_fifo_ctrl_pkg::*;
#(
    parameter int          NCH        = 2,
    parameter int          CNT_W      = 9,
    parameter int          LSIZE      = 9,
    parameter int          FULL_LEN   = 256,
    parameter int          THRESHOLD  = 200,
    parameter logic [23:0] FRAME_SYNC = FS_OFF
) (
    input  logic                      clock,
    input  logic                      rst_n,
    input  logic [NCH-1:0]            enable,
    input  logic [NCH*CNT_W-1:0]      count,
    input  logic [NCH-1:0]            tail_status,
    input  logic [NCH*LSIZE-1:0]      tail_len,
    input  logic [NCH-1:0]            frame_sync,
    read_fifo_multi_req_ctrl_if.master req_if,
    output logic                      busy
);
    localparam int IW    = ch_idx_w(NCH);
    localparam int CMP_W = (CNT_W > $clog2(FULL_LEN + 1)) ? CNT_W : $clog2(FULL_LEN + 1);

    // Refill when free space exceeds one full burst.
    localparam logic [CMP_W-1:0] TRIG_LVL  = CMP_W'(FULL_LEN - THRESHOLD);
    localparam logic [LSIZE-1:0] BURST_LEN = LSIZE'(THRESHOLD);
    localparam bit               SYNC_ON   = (FRAME_SYNC == FS_ON);

    state_e           state_q, state_d;
    logic [NCH-1:0]   trig_q, trig_d;
    logic [NCH-1:0]   armed_q, armed_d;
    logic             burst_req_q, burst_req_d;
    logic             tail_req_q, tail_req_d;
    logic [IW-1:0]    req_ch_q, req_ch_d;
    logic [LSIZE-1:0] req_len_q, req_len_d;
    logic             busy_q, busy_d;

    logic             advance;
    logic [IW-1:0]    gnt_idx;
    logic             gnt_vld;
    logic             sel_tail;
    logic [LSIZE-1:0] sel_len;

    // Per-channel arming and trigger. Dropping enable disarms, and that wins over
    // a coincident frame_sync. Without frame sync every channel counts as armed.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CMP_W-1:0] cnt_ext;
        assign cnt_ext    = CMP_W'(count[i*CNT_W +: CNT_W]);
        assign armed_d[i] = enable[i] & (armed_q[i] | frame_sync[i]);
        assign trig_d[i]  = enable[i] & (SYNC_ON ? armed_q[i] : 1'b1) & (cnt_ext < TRIG_LVL);
    end

    rr_arbiter #(
        .NCH (NCH)
    ) u_arb (
        .clock   (clock),
        .rst_n   (rst_n),
        .req     (trig_q),
        .advance (advance),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign sel_tail = tail_status[gnt_idx];
    assign sel_len  = tail_len[int'(gnt_idx)*LSIZE +: LSIZE];

    always_comb begin
        state_d     = state_q;
        burst_req_d = burst_req_q;
        tail_req_d  = tail_req_q;
        req_ch_d    = req_ch_q;
        req_len_d   = req_len_q;
        advance     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    advance  = 1'b1;
                    req_ch_d = gnt_idx;
                    if (sel_tail) begin
                        req_len_d = sel_len;
                        // Empty tail: nothing to fetch, but the grant still
                        // counts so the pointer moves on.
                        if (sel_len == '0) begin
                            state_d = ST_FSH;
                        end else begin
                            tail_req_d = 1'b1;
                            state_d    = ST_REQ;
                        end
                    end else begin
                        req_len_d   = BURST_LEN;
                        burst_req_d = 1'b1;
                        state_d     = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (req_if.resp) begin
                    burst_req_d = 1'b0;
                    tail_req_d  = 1'b0;
                    state_d     = req_if.done ? ST_FSH : ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (req_if.done) begin
                    state_d = ST_FSH;
                end
            end
            ST_FSH:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            trig_q      <= '0;
            armed_q     <= '0;
            burst_req_q <= 1'b0;
            tail_req_q  <= 1'b0;
            req_ch_q    <= '0;
            req_len_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            trig_q      <= trig_d;
            armed_q     <= armed_d;
            burst_req_q <= burst_req_d;
            tail_req_q  <= tail_req_d;
            req_ch_q    <= req_ch_d;
            req_len_q   <= req_len_d;
            busy_q      <= busy_d;
        end
    end

    assign req_if.burst_req = burst_req_q;
    assign req_if.tail_req  = tail_req_q;
    assign req_if.req_ch    = req_ch_q;
    assign req_if.req_len   = req_len_q;
    assign busy             = busy_q;

endmodule
